fetch_sequencer: RTL and testbench



---
 rtl/fetch_sequencer_if.sv | 26 ++
 rtl/fetch_sequencer.sv | 119 +++++++++++
 tb/tb_fetch_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch port bundle: instruction-memory req/ack, execute redirect, decode hand-off.
interface fetch_sequencer_if;
   // imem_req rises with imem_addr and both hold until imem_ack, redirect, timeout or reset;
   // imem_ack is honoured only while imem_req=1; inst_valid holds its word until stall=0.
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_addr;
   logic        stall;
   logic        inst_valid;
   logic [31:0] inst_code;
   logic [31:0] inst_address;
   logic        fetch_error;

   modport master (
      output imem_req, imem_addr, inst_valid, inst_code, inst_address, fetch_error,
      input  imem_ack, imem_rdata, redirect_valid, redirect_addr, stall
   );

   modport slave (
      input  imem_req, imem_addr, inst_valid, inst_code, inst_address, fetch_error,
      output imem_ack, imem_rdata, redirect_valid, redirect_addr, stall
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Multicycle instruction-fetch controller: owns the PC, sequences imem reads, applies redirects.
// Define MISALIGN_TRAP_EN to trap misaligned redirect targets instead of aligning them.
module fetch_sequencer #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WAIT   = 15,
   parameter logic [31:0] NOP_CODE   = 32'h0000_0013
) (
   input  logic              clock,
   input  logic              reset,
   fetch_sequencer_if.master bus,
   output logic [1:0]        debug_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      OUT  = 2'd2,
      ERR  = 2'd3
   } state_t;

   localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

   state_t      state, state_next;
   logic [31:0] pc, pc_next;
   logic [7:0]  wait_cnt, wait_next;
   logic        req_next;
   logic [31:0] addr_next;
   logic        valid_next;
   logic [31:0] code_next;
   logic [31:0] address_next;
   logic        error_next;
   logic [31:0] redirect_aligned;

   assign redirect_aligned = bus.redirect_addr & ~32'h0000_0003;
   assign debug_state      = state;

   always_comb begin
      state_next   = state;
      pc_next      = pc;
      wait_next    = wait_cnt;
      valid_next   = bus.inst_valid;
      code_next    = bus.inst_code;
      address_next = bus.inst_address;

      case (state)
         IDLE: state_next = REQ;
         REQ: begin
            if (bus.imem_ack) begin
               code_next    = bus.imem_rdata;
               address_next = pc;
               valid_next   = 1'b1;
               pc_next      = pc + 32'd4;
               wait_next    = '0;
               state_next   = OUT;
            end else if (wait_cnt == WAIT_LIMIT) begin
               state_next = ERR;
            end else begin
               wait_next = wait_cnt + 8'd1;
            end
         end
         OUT: begin
            if (!bus.stall) begin
               valid_next = 1'b0;
               state_next = REQ;
            end
         end
         default: valid_next = 1'b0;
      endcase

      // A redirect discards any word returning this cycle and leaves the PC untouched by it.
      if (bus.redirect_valid && state != ERR) begin
         valid_next   = 1'b0;
         wait_next    = '0;
         code_next    = bus.inst_code;
         address_next = bus.inst_address;
         pc_next      = pc;
`ifdef MISALIGN_TRAP_EN
         if (bus.redirect_addr[1:0] != 2'b00) begin
            state_next = ERR;
         end else begin
            pc_next    = redirect_aligned;
            state_next = IDLE;
         end
`else
         pc_next    = redirect_aligned;
         state_next = IDLE;
`endif
      end

      error_next = bus.fetch_error | (state_next == ERR);
      req_next   = (state_next == REQ);
      addr_next  = req_next ? pc_next : bus.imem_addr;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state            <= IDLE;
         pc               <= RESET_ADDR;
         wait_cnt         <= '0;
         bus.imem_req     <= 1'b0;
         bus.imem_addr    <= RESET_ADDR;
         bus.inst_valid   <= 1'b0;
         bus.inst_code    <= NOP_CODE;
         bus.inst_address <= RESET_ADDR;
         bus.fetch_error  <= 1'b0;
      end else begin
         state            <= state_next;
         pc               <= pc_next;
         wait_cnt         <= wait_next;
         bus.imem_req     <= req_next;
         bus.imem_addr    <= addr_next;
         bus.inst_valid   <= valid_next;
         bus.inst_code    <= code_next;
         bus.inst_address <= address_next;
         bus.fetch_error  <= error_next;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: memory responder, scoreboard of fetched words, directed scenarios.
`timescale 1ns/1ps
module tb_fetch_sequencer;

   localparam logic [31:0] NOP_CODE = 32'h0000_0013;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] debug_state;

   fetch_sequencer_if bus();

   fetch_sequencer dut (
      .clock       (clock),
      .reset       (reset),
      .bus         (bus),
      .debug_state (debug_state)
   );

   // clock / reset
   always #5 clock = ~clock;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] exp_q[$];
   logic [31:0] exp_fetch = 32'h0;
   logic        ack_on = 1'b1;
   logic        prev_req = 1'b0;
   logic        prev_valid = 1'b0;
   logic [31:0] prev_addr = 32'h0;
   logic [31:0] prev_code = 32'h0;
   logic [31:0] prev_address = 32'h0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hA5C3_0F69;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: observe outputs, answer the memory port, then advance past the edge.
   task automatic tick();
      logic [63:0] e;
      logic        was_reset;
      if (!reset) begin
         if (bus.imem_req && !prev_req) check_eq("req_addr", bus.imem_addr, exp_fetch);
         if (bus.imem_req && prev_req)  check_eq("addr_stable", bus.imem_addr, prev_addr);
         if (bus.inst_valid)            check_eq("no_req_while_valid", {31'd0, bus.imem_req}, 32'd0);
         if (bus.inst_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_valid", {31'd0, bus.inst_valid}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check_eq("inst_address", bus.inst_address, e[63:32]);
               check_eq("inst_code", bus.inst_code, e[31:0]);
            end
         end
         if (bus.inst_valid && prev_valid) begin
            check_eq("hold_code", bus.inst_code, prev_code);
            check_eq("hold_address", bus.inst_address, prev_address);
         end
      end
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'h0;
      if (bus.imem_req && ack_on) begin
         bus.imem_ack   = 1'b1;
         bus.imem_rdata = mem_word(bus.imem_addr);
         if (!reset && !bus.redirect_valid) begin
            exp_q.push_back({bus.imem_addr, bus.imem_rdata});
            exp_fetch = bus.imem_addr + 32'd4;
         end
      end
      if (!reset && bus.redirect_valid && !bus.fetch_error) begin
`ifdef MISALIGN_TRAP_EN
         if (bus.redirect_addr[1:0] == 2'b00) exp_fetch = bus.redirect_addr;
`else
         exp_fetch = bus.redirect_addr & ~32'h0000_0003;
`endif
      end
      prev_req     = bus.imem_req;
      prev_addr    = bus.imem_addr;
      prev_valid   = bus.inst_valid;
      prev_code    = bus.inst_code;
      prev_address = bus.inst_address;
      was_reset    = reset;
      @(posedge clock);
      #1;
      if (was_reset) begin
         prev_req   = 1'b0;
         prev_valid = 1'b0;
         exp_q.delete();
         exp_fetch  = 32'h0;
      end
   endtask

   task automatic run_until_valid(output int cycles);
      cycles = 0;
      while (!bus.inst_valid && cycles < 50) begin
         tick();
         cycles++;
      end
      check_eq("valid_wait", {31'd0, bus.inst_valid}, 32'd1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic pulse_redirect(input logic [31:0] target);
      bus.redirect_valid = 1'b1;
      bus.redirect_addr  = target;
      tick();
      bus.redirect_valid = 1'b0;
   endtask

   initial begin
      int c;
      int req_cycles;
      bus.imem_ack       = 1'b0;
      bus.imem_rdata     = 32'h0;
      bus.redirect_valid = 1'b0;
      bus.redirect_addr  = 32'h0;
      bus.stall          = 1'b0;

      // reset values
      reset = 1'b1;
      tick();
      tick();
      check_eq("rst_req", {31'd0, bus.imem_req}, 32'd0);
      check_eq("rst_addr", bus.imem_addr, 32'h0);
      check_eq("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
      check_eq("rst_code", bus.inst_code, NOP_CODE);
      check_eq("rst_address", bus.inst_address, 32'h0);
      check_eq("rst_error", {31'd0, bus.fetch_error}, 32'd0);
      check_eq("rst_state", {30'd0, debug_state}, 32'd0);
      reset = 1'b0;

      // zero-wait sequence 0,4,8 then stall at 8
      run_until_valid(c);
      check_eq("first_valid_cycles", 32'(c), 32'd2);
      tick();
      run_until_valid(c);
      tick();
      run_until_valid(c);
      check_eq("at_addr8", bus.inst_address, 32'h8);
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("stall_valid", {31'd0, bus.inst_valid}, 32'd1);
         check_eq("stall_no_req", {31'd0, bus.imem_req}, 32'd0);
      end
      bus.stall = 1'b0;
      tick();
      check_eq("req_after_stall", {31'd0, bus.imem_req}, 32'd1);
      check_eq("addr_after_stall", bus.imem_addr, 32'hC);
      run_until_valid(c);
      tick();

      // redirect coinciding with the ack for address 4
      do_reset();
      run_until_valid(c);
      tick();
      check_eq("req4_addr", bus.imem_addr, 32'h4);
      pulse_redirect(32'h0000_0100);
      check_eq("bubble_req", {31'd0, bus.imem_req}, 32'd0);
      check_eq("bubble_valid", {31'd0, bus.inst_valid}, 32'd0);
      tick();
      check_eq("redir_req", {31'd0, bus.imem_req}, 32'd1);
      check_eq("redir_addr", bus.imem_addr, 32'h100);
      run_until_valid(c);
      tick();

      // misaligned redirect target
      pulse_redirect(32'h0000_0102);
`ifdef MISALIGN_TRAP_EN
      check_eq("trap_error", {31'd0, bus.fetch_error}, 32'd1);
      check_eq("trap_state", {30'd0, debug_state}, 32'd3);
      check_eq("trap_req", {31'd0, bus.imem_req}, 32'd0);
`else
      check_eq("align_bubble", {31'd0, bus.imem_req}, 32'd0);
      tick();
      check_eq("align_req", {31'd0, bus.imem_req}, 32'd1);
      check_eq("align_addr", bus.imem_addr, 32'h100);
      check_eq("align_error", {31'd0, bus.fetch_error}, 32'd0);
`endif

      // PC wrap at the top of the address space
      do_reset();
      tick();
      pulse_redirect(32'hFFFF_FFFC);
      tick();
      check_eq("top_addr", bus.imem_addr, 32'hFFFF_FFFC);
      run_until_valid(c);
      tick();
      check_eq("wrap_req", {31'd0, bus.imem_req}, 32'd1);
      check_eq("wrap_addr", bus.imem_addr, 32'h0);
      check_eq("wrap_error", {31'd0, bus.fetch_error}, 32'd0);

      // memory never answers: timeout, sticky error, redirect ignored
      do_reset();
      ack_on = 1'b0;
      req_cycles = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.imem_req) req_cycles++;
         tick();
      end
      check_eq("timeout_req_cycles", 32'(req_cycles), 32'd16);
      check_eq("timeout_error", {31'd0, bus.fetch_error}, 32'd1);
      check_eq("timeout_req_low", {31'd0, bus.imem_req}, 32'd0);
      check_eq("timeout_valid", {31'd0, bus.inst_valid}, 32'd0);
      pulse_redirect(32'h0000_0200);
      tick();
      tick();
      check_eq("err_sticky", {31'd0, bus.fetch_error}, 32'd1);
      check_eq("err_no_req", {31'd0, bus.imem_req}, 32'd0);
      check_eq("err_state", {30'd0, debug_state}, 32'd3);
      do_reset();
      check_eq("err_cleared", {31'd0, bus.fetch_error}, 32'd0);
      check_eq("err_reset_state", {30'd0, debug_state}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
